branch_redirect_ctrl: RTL and testbench

BRANCH_REDIRECT_CTRL -- requirements
Module: branch_redirect_ctrl

---
 rtl/branch_redirect_ctrl.sv | 131 +++++++++++++
 tb/tb_branch_redirect_ctrl.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/branch_redirect_ctrl.sv
// Branch/jump redirect controller.
// Converts a taken branch or jump resolved in EX into a PC redirect.
// While the redirect is in flight it flushes IF/ID and ID/EX. It also keeps
// sticky misalignment status and saturating branch/redirect statistics.
//
// Fetch handshake: imem_ready is a level from instruction memory. It means
// the address currently presented (pc_target while PCSrc=1) was accepted this
// cycle. The redirect is held until the PC select reaches memory: it stays
// up until a cycle that has stall_in=0 (REDIRECT) and imem_ready=1.
module branch_redirect_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Branch_ex,
    input  logic             Btaken,
    input  logic             Jump_ex,
    input  logic [31:0]      target_ex,
    input  logic             stall_in,
    input  logic             imem_ready,
    output logic             PCSrc,
    output logic [31:0]      pc_target,
    output logic             flush_ifid,
    output logic             flush_idex,
    output logic             redirect_busy,
    output logic             misalign_err,
    output logic [CNT_W-1:0] branch_count,
    output logic [CNT_W-1:0] taken_count,
    output logic [1:0]       state_dbg
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        REDIRECT   = 2'd1,
        WAIT_FETCH = 2'd2
    } state_t;

    state_t           state_q;
    logic             busy_q;
    logic             misalign_q;
    logic [31:0]      pc_target_q;
    logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
    logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;

    logic idle_free;
    logic accept;
    logic branch_evt;

    // Requests are only seen in IDLE with the pipe moving. While busy, the
    // EX slot holds a wrong-path instruction that is being flushed.
    assign idle_free  = (state_q == IDLE) && !stall_in;
    assign accept     = idle_free && ((Branch_ex && Btaken) || Jump_ex);
    assign branch_evt = idle_free && Branch_ex && !Jump_ex;

    // Redirect FSM. The Moore outputs are registered alongside the state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            misalign_q  <= 1'b0;
            pc_target_q <= 32'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_q     <= REDIRECT;
                        busy_q      <= 1'b1;
                        pc_target_q <= {target_ex[31:2], 2'b00};
                        if (target_ex[1:0] != 2'b00) begin
                            misalign_q <= 1'b1;
                        end
                    end
                end
                REDIRECT: begin
                    if (!stall_in) begin
                        if (imem_ready) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= WAIT_FETCH;
                        end
                    end
                end
                WAIT_FETCH: begin
                    if (imem_ready) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Saturating next-state for the statistics counters.
    always_comb begin
        branch_cnt_d = branch_cnt_q;
        taken_cnt_d  = taken_cnt_q;
        if (branch_evt && (branch_cnt_q != {CNT_W{1'b1}})) begin
            branch_cnt_d = branch_cnt_q + CNT_W'(1);
        end
        if (accept && (taken_cnt_q != {CNT_W{1'b1}})) begin
            taken_cnt_d = taken_cnt_q + CNT_W'(1);
        end
    end

    // Statistics counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            branch_cnt_q <= '0;
            taken_cnt_q  <= '0;
        end else begin
            branch_cnt_q <= branch_cnt_d;
            taken_cnt_q  <= taken_cnt_d;
        end
    end

    assign PCSrc         = busy_q;
    assign flush_ifid    = busy_q;
    assign flush_idex    = busy_q;
    assign redirect_busy = busy_q;
    assign misalign_err  = misalign_q;
    assign pc_target     = pc_target_q;
    assign branch_count  = branch_cnt_q;
    assign taken_count   = taken_cnt_q;
    assign state_dbg     = state_q;

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Directed bench for branch_redirect_ctrl (CNT_W=4 so saturation is reachable).
module tb_branch_redirect_ctrl;

  localparam int CW = 4;
  localparam int EW = 4 + 1 + 32 + 2 * CW;

  logic          clk;
  logic          reset;
  logic          Branch_ex;
  logic          Btaken;
  logic          Jump_ex;
  logic [31:0]   target_ex;
  logic          stall_in;
  logic          imem_ready;
  logic          PCSrc;
  logic [31:0]   pc_target;
  logic          flush_ifid;
  logic          flush_idex;
  logic          redirect_busy;
  logic          misalign_err;
  logic [CW-1:0] branch_count;
  logic [CW-1:0] taken_count;
  logic [1:0]    state_dbg;

  branch_redirect_ctrl #(.CNT_W(CW)) dut (
    .clk           (clk),
    .reset         (reset),
    .Branch_ex     (Branch_ex),
    .Btaken        (Btaken),
    .Jump_ex       (Jump_ex),
    .target_ex     (target_ex),
    .stall_in      (stall_in),
    .imem_ready    (imem_ready),
    .PCSrc         (PCSrc),
    .pc_target     (pc_target),
    .flush_ifid    (flush_ifid),
    .flush_idex    (flush_idex),
    .redirect_busy (redirect_busy),
    .misalign_err  (misalign_err),
    .branch_count  (branch_count),
    .taken_count   (taken_count),
    .state_dbg     (state_dbg)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard state
  logic [EW-1:0] exp_q[$];
  int            total_cnt = 0;
  int            pass_cnt  = 0;

  // reference state: the busy flag during the current cycle, plus the
  // expected values of the data outputs
  logic          m_busy;
  logic          m_mis;
  logic [31:0]   m_pc;
  logic [CW-1:0] m_bc;
  logic [CW-1:0] m_tc;

  task automatic model_clear();
    m_busy = 1'b0;
    m_mis  = 1'b0;
    m_pc   = 32'd0;
    m_bc   = '0;
    m_tc   = '0;
  endtask

  task automatic check_next(input string tag);
    logic [EW-1:0] exp_v;
    logic [EW-1:0] obs_v;
    obs_v = {PCSrc, flush_ifid, flush_idex, redirect_busy, misalign_err,
             pc_target, branch_count, taken_count};
    total_cnt++;
    if (exp_q.size() == 0) begin
      $error("FAIL %s scoreboard empty observed=%h", tag, obs_v);
    end else begin
      exp_v = exp_q.pop_front();
      assert (obs_v === exp_v) pass_cnt++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs_v, exp_v);
    end
  endtask

  // Drive one cycle of inputs. eb is the redirect_busy value expected after
  // the edge. The counters, target and sticky flag follow from the inputs.
  task automatic step(input string tag, input logic br, input logic bt,
                      input logic jp, input logic [31:0] tgt,
                      input logic st, input logic rdy, input logic eb);
    Branch_ex  = br;
    Btaken     = bt;
    Jump_ex    = jp;
    target_ex  = tgt;
    stall_in   = st;
    imem_ready = rdy;
    if (!m_busy && !st) begin
      if (jp || (br && bt)) begin
        m_pc = {tgt[31:2], 2'b00};
        if (tgt[1:0] != 2'b00) m_mis = 1'b1;
        if (m_tc != 4'hF) m_tc = m_tc + 4'd1;
      end
      if (br && !jp) begin
        if (m_bc != 4'hF) m_bc = m_bc + 4'd1;
      end
    end
    m_busy = eb;
    exp_q.push_back({eb, eb, eb, eb, m_mis, m_pc, m_bc, m_tc});
    @(posedge clk);
    #1;
    check_next(tag);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_clear();
    @(posedge clk);
    #1;
    exp_q.push_back('0);
    check_next("reset_state");
    reset = 1'b0;
  endtask

  initial begin
    reset      = 1'b1;
    Branch_ex  = 1'b0;
    Btaken     = 1'b0;
    Jump_ex    = 1'b0;
    target_ex  = 32'd0;
    stall_in   = 1'b0;
    imem_ready = 1'b1;
    model_clear();
    @(posedge clk);
    do_reset();

    // taken branch: one-cycle redirect
    step("taken_br",     1, 1, 0, 32'h0000_0100, 0, 1, 1);
    step("taken_br_end", 0, 0, 0, 32'h0,         0, 1, 0);

    // not-taken branch: counted, no flush
    step("nottaken_br",  1, 0, 0, 32'h0000_0500, 0, 1, 0);

    // stall in IDLE blocks the request and the count
    step("idle_stall",   1, 1, 0, 32'h0000_0600, 1, 1, 0);

    // jump with stall then slow fetch; branch pulses inside are ignored
    step("slow_jump",    0, 0, 1, 32'h0000_0200, 0, 1, 1);
    step("slow_stall1",  1, 1, 0, 32'h0000_0700, 1, 1, 1);
    step("slow_stall2",  0, 0, 0, 32'h0,         1, 1, 1);
    step("slow_rdy0_a",  0, 0, 0, 32'h0,         0, 0, 1);
    step("slow_rdy0_b",  1, 1, 1, 32'h0000_0800, 0, 0, 1);
    step("slow_rdy0_c",  1, 0, 0, 32'h0,         1, 0, 1);
    step("slow_rdy0_d",  0, 0, 0, 32'h0,         0, 0, 1);
    step("slow_wf_exit", 0, 0, 0, 32'h0,         1, 1, 0);

    // jump and branch together with a misaligned target
    step("misalign_jmp", 1, 1, 1, 32'h0000_0103, 0, 1, 1);
    step("misalign_end", 0, 0, 0, 32'h0,         0, 1, 0);
    step("sticky_hold",  1, 0, 0, 32'h0,         0, 1, 0);

    // async reset while in WAIT_FETCH, then a clean redirect
    step("pre_rst_jmp",  0, 0, 1, 32'h0000_0300, 0, 0, 1);
    step("pre_rst_wf",   0, 0, 0, 32'h0,         0, 0, 1);
    #2;
    reset = 1'b1;
    model_clear();
    #1;
    exp_q.push_back('0);
    check_next("async_reset");
    @(posedge clk);
    #1;
    reset = 1'b0;
    step("post_rst_jmp", 0, 0, 1, 32'h0000_0040, 0, 1, 1);
    step("post_rst_end", 0, 0, 0, 32'h0,         0, 1, 0);

    // saturation: 20 taken branches on 4-bit counters
    do_reset();
    for (int i = 0; i < 20; i++) begin
      step("sat_take", 1, 1, 0, 32'h0000_1000 + 32'(i * 4), 0, 1, 1);
      step("sat_idle", 0, 0, 0, 32'h0, 0, 1, 0);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
